mdu_sequencer: RTL and testbench

- Multi-cycle controller for the M-extension unit, sitting beside the execute stage.
- Accepts one MUL/DIV/REM op per issue and freezes the pipeline via stall while the op runs.
- Runs a fixed-latency multiply path and an iterative radix-2 restoring divider.
- Returns result plus destination register for injection into the memory-stage register.

---
 rtl/mdu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MUL/DIV/REM controller beside the execute stage.
// Latency: multiply MUL_LATENCY cycles, divide 33 cycles, divide special cases 1 cycle.
// Backpressure: stall freezes fetch/decode/execute while an op runs; flush kills it.
//
// Ports: clk/rst (sync, active-high); op_valid/op_funct3/op_rs1/op_rs2/op_rd issue
// an op; flush kills an in-flight op; stall/busy report occupancy; result_valid
// strobes result/result_rd for one cycle, which then hold until the next result.
// Optional: define MDU_DIV_EARLY_EN to resolve divides with |rs1| < |rs2| at issue.
module mdu_sequencer #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_rs1,
  input  logic [XLEN-1:0] op_rs2,
  input  logic [4:0]      op_rd,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [4:0]          cnt;
  logic [2:0]          f3_q;
  logic [4:0]          rd_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN-1:0]     quo_q, rem_q, dvs_q;
  logic                neg_q, neg_r;
  logic [XLEN-1:0]     res_hold;
  logic [4:0]          rd_hold;
  logic [XLEN-1:0]     result_comb;

  // A new op may enter from IDLE or from the DONE cycle (back-to-back).
  logic issue;
  assign issue = op_valid && !flush && (state == S_IDLE || state == S_DONE);

  // Multiply operands: sign-extend per funct3, then a modular 2*XLEN product
  // yields the correct bits for all signedness combinations.
  logic              is_mul, a_sgn, b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  assign is_mul = !op_funct3[2];
  assign a_sgn  = (op_funct3 == 3'b000 || op_funct3 == 3'b001 || op_funct3 == 3'b010) && op_rs1[XLEN-1];
  assign b_sgn  = (op_funct3 == 3'b000 || op_funct3 == 3'b001) && op_rs2[XLEN-1];
  assign mul_a  = {{XLEN{a_sgn}}, op_rs1};
  assign mul_b  = {{XLEN{b_sgn}}, op_rs2};
  assign mul_p  = mul_a * mul_b;

  // Divide operands: magnitudes plus recorded result signs.
  logic            div_sgn, sa, sb, div_zero, div_ovf, div_early, div_special;
  logic [XLEN-1:0] mag_a, mag_b;
  assign div_sgn  = !op_funct3[0];
  assign sa       = div_sgn && op_rs1[XLEN-1];
  assign sb       = div_sgn && op_rs2[XLEN-1];
  assign mag_a    = sa ? -op_rs1 : op_rs1;
  assign mag_b    = sb ? -op_rs2 : op_rs2;
  assign div_zero = (op_rs2 == '0);
  assign div_ovf  = div_sgn && (op_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (op_rs2 == '1);
`ifdef MDU_DIV_EARLY_EN
  assign div_early = (mag_a < mag_b);
`else
  assign div_early = 1'b0;
`endif
  assign div_special = div_zero || div_ovf || div_early;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0] div_shift, div_diff;
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (issue) begin
          if (is_mul) state_nxt = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
          else        state_nxt = div_special ? S_DONE : S_DIV;
        end
      end
      S_MUL: begin
        if (flush)            state_nxt = S_IDLE;
        else if (cnt == 5'd1) state_nxt = S_DONE;
      end
      S_DIV: begin
        if (flush)             state_nxt = S_IDLE;
        else if (cnt == 5'd31) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sign fixup of the divider outputs happens here, as DONE is presented.
  always_comb begin
    result_comb = '0;
    if (!f3_q[2])     result_comb = (f3_q[1:0] == 2'b00) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
    else if (f3_q[1]) result_comb = neg_r ? -rem_q : rem_q;
    else              result_comb = neg_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      res_hold <= '0;
      rd_hold  <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        f3_q   <= op_funct3;
        rd_q   <= op_rd;
        prod_q <= mul_p;
        cnt    <= is_mul ? 5'(MUL_LATENCY - 1) : 5'd0;
        dvs_q  <= mag_b;
        // Special cases preload the final quotient/remainder with no sign fixup.
        if (div_zero) begin
          quo_q <= '1;       rem_q <= op_rs1; neg_q <= 1'b0; neg_r <= 1'b0;
        end else if (div_ovf) begin
          quo_q <= op_rs1;   rem_q <= '0;     neg_q <= 1'b0; neg_r <= 1'b0;
        end else if (div_early) begin
          quo_q <= '0;       rem_q <= op_rs1; neg_q <= 1'b0; neg_r <= 1'b0;
        end else begin
          quo_q <= mag_a;    rem_q <= '0;     neg_q <= sa ^ sb; neg_r <= sa;
        end
      end else if (state == S_MUL) begin
        cnt <= cnt - 5'd1;
      end else if (state == S_DIV) begin
        cnt <= cnt + 5'd1;  // wraps 31 -> 0 on the last iteration
        if (!div_diff[XLEN]) begin
          rem_q <= div_diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= div_shift[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end
      if (state == S_DONE) begin
        res_hold <= result_comb;
        rd_hold  <= rd_q;
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign stall        = !flush && ((state == S_IDLE && issue) || state == S_MUL || state == S_DIV);
  assign result       = (state == S_DONE) ? result_comb : res_hold;
  assign result_rd    = (state == S_DONE) ? rd_q : rd_hold;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer with an arithmetic reference model.
// Stimulus pushes expected {result, rd, due cycle}; a negedge monitor pops and compares.
// Covers reset, multiply/divide variants, special cases, flush, back-to-back and reset mid-op.
module tb_mdu_sequencer;
  localparam int ML = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_funct3 = '0;
  logic [31:0] op_rs1 = '0, op_rs2 = '0;
  logic [4:0]  op_rd = '0;
  logic        flush = 1'b0;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  mdu_sequencer #(.XLEN(32), .MUL_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_funct3(op_funct3),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rd(op_rd), .flush(flush),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .result_rd(result_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: RISC-V M semantics via 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: p = (b == 0) ? -64'sd1 : sa / sb;
      3'd5: p = (b == 0) ? -64'sd1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return ML;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_DIV_EARLY_EN
    begin
      longint ma, mb;
      ma = f[0] ? longint'({32'd0, a}) : longint'($signed(a));
      mb = f[0] ? longint'({32'd0, b}) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 1;
    end
`endif
    return 33;
  endfunction

  // Monitor: compares every retiring result against the scoreboard head.
  exp_t        e;
  logic [31:0] last_res;
  logic [4:0]  last_rd;
  bit          have_last = 0;
  always @(negedge clk) begin
    if (rst) begin
      have_last = 0;
    end else begin
      if (op_valid && busy && !result_valid) begin
        checks++;
        errors++;
        $display("FAIL protocol @cyc %0d: op_valid while busy", cyc);
      end
      if (!flush && busy && !result_valid) chk("stall_busy", 32'(stall), 32'd1);
      if (result_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result @cyc %0d: got %h expected none", cyc, result);
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("result_rd", 32'(result_rd), 32'(e.rd));
          chk("latency", 32'(cyc), 32'(e.due));
          chk("stall_done", 32'(stall), 32'd0);
        end
        last_res  = result;
        last_rd   = result_rd;
        have_last = 1;
      end else if (have_last) begin
        chk("hold_result", result, last_res);
        chk("hold_rd", 32'(result_rd), 32'(last_rd));
      end
    end
  end

  // Driver helpers; all driving happens 1 time unit after a rising edge.
  task automatic wait_slot();
    int n = 0;
    @(posedge clk); #1;
    while (busy && !result_valid) begin
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL wait_slot: busy for %0d cycles, expected idle", n);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
    logic from_idle;
    from_idle = !busy;
    op_valid = 1'b1; op_funct3 = f; op_rs1 = a; op_rs2 = b; op_rd = d;
    sbq.push_back('{ref_result(f, a, b), d, cyc + ref_lat(f, a, b)});
    #1;
    if (from_idle) chk("stall_issue", 32'(stall), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    wait_slot();
    drive_op(f, a, b, d);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!result_valid) begin
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL wait_done: no result_valid in %0d cycles", n);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(result_rd), 32'd0);
    rst = 1'b0;

    // MUL 7 * -3: stall across the issue and MUL cycles, result at N+3.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    chk("mul_stall_n1", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("mul_stall_n2", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("mul_valid_n3", 32'(result_valid), 32'd1);

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd7);
    issue(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd8);
    issue(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd9);
    issue(3'b101, 32'd100, 32'd0, 5'd10);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd0);

    // Flush a running divide at N+10, then re-issue from IDLE at N+11.
    issue(3'b101, 32'd1000, 32'd7, 5'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    void'(sbq.pop_back());
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", 32'(busy), 32'd0);
    drive_op(3'b000, 32'd6, 32'd7, 5'd4);

    // Back-to-back: DIVU issued in the DONE cycle of a MULHU.
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13);
    wait_done();
    drive_op(3'b101, 32'd9, 32'd2, 5'd14);
    issue(3'b101, 32'd3, 32'd9, 5'd15);
    issue(3'b110, 32'hFFFF_FFFD, 32'd9, 5'd16);

    // Reset in the middle of a divide.
    issue(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd17);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    void'(sbq.pop_back());
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", 32'(result_rd), 32'd0);
    rst = 1'b0;

    // Randomized ops, occasionally issued back-to-back in the DONE cycle.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = rand_opnd();
      b = rand_opnd();
      if ($urandom_range(0, 3) == 0 && busy) begin
        wait_done();
        drive_op(f, a, b, 5'($urandom));
      end else begin
        issue(f, a, b, 5'($urandom));
      end
    end

    wait_slot();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
